// File: rtl/logic_pkg.sv
// Shared definitions for the logic operand loader: op codes, FSM states, operand widths.
package logic_pkg;

  localparam int OPERAND_W = 4;
  localparam int NOT_W     = 8;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  function automatic logic [3:0] op_onehot(input logic [1:0] op);
    return 4'b0001 << op;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser plus counter debouncer for one active-low key; emits a one-cycle
// pulse on the accepted released->pressed edge.
module key_debounce #(
  parameter int DEB_CYCLES  = 250000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   key_sample;

  assign key_sample = sync_q[SYNC_STAGES-1];

  // The count tracks consecutive samples that disagree with the accepted level;
  // any agreeing sample (a bounce back) clears it.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (key_sample != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = key_sample;
        press_d = ~key_sample;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/logic_operand_loader.sv
// Captures switch operands on a debounced load key, cycles the op code on the op key
// and offers {x,y,z,op,en} downstream with valid/ready. Option: LOGIC_AUTO_RELOAD_EN.
module logic_operand_loader
  import logic_pkg::*;
#(
  parameter int DEB_CYCLES  = 250000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NOT_W-1:0]     sw,
  input  logic                 load_key_n,
  input  logic                 op_key_n,
  output logic [OPERAND_W-1:0] x,
  output logic [OPERAND_W-1:0] y,
  output logic [NOT_W-1:0]     z,
  output logic [1:0]           op,
  output logic [3:0]           en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           dbg_state,
  output logic [1:0]           dbg_key_level
);

  // Handshake: out_valid is high only in HOLD; a transfer happens on a cycle with
  // out_valid && out_ready, and all outputs stay frozen until that cycle.

  logic load_press, op_press, load_level, op_level;
  logic [NOT_W-1:0] sw_cap;
  logic             auto_trig;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_load_deb (
    .clk(clk), .rst(rst), .key_n(load_key_n), .level(load_level), .press(load_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_op_deb (
    .clk(clk), .rst(rst), .key_n(op_key_n), .level(op_level), .press(op_press)
  );

  state_t                 state_q, state_d;
  logic [OPERAND_W-1:0]   x_q, x_d, y_q, y_d;
  logic [NOT_W-1:0]       z_q, z_d;
  logic [1:0]             op_q, op_d;
  logic [3:0]             en_q, en_d;

`ifdef LOGIC_AUTO_RELOAD_EN
  logic [SYNC_STAGES-1:0][NOT_W-1:0] sw_sync_q, sw_sync_d;

  always_comb begin
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], sw};
  end

  always_ff @(posedge clk) begin
    if (rst) sw_sync_q <= '0;
    else     sw_sync_q <= sw_sync_d;
  end

  assign sw_cap    = sw_sync_q[SYNC_STAGES-1];
  assign auto_trig = (sw_cap != z_q);
`else
  assign sw_cap    = sw;
  assign auto_trig = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    op_d    = op_q;
    en_d    = en_q;
    unique case (state_q)
      IDLE: begin
        // op advances in the same cycle a simultaneous load is seen, so the
        // following offer carries the new op.
        if (op_press) begin
          op_d = op_q + 2'd1;
          en_d = op_onehot(op_d);
        end
        if (load_press || auto_trig) state_d = CAPTURE;
      end
      CAPTURE: begin
        x_d     = sw_cap[OPERAND_W-1:0];
        y_d     = sw_cap[NOT_W-1:OPERAND_W];
        z_d     = sw_cap;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      op_q    <= OP_AND;
      en_q    <= 4'b0001;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      op_q    <= op_d;
      en_q    <= en_d;
    end
  end

  assign x             = x_q;
  assign y             = y_q;
  assign z             = z_q;
  assign op            = op_q;
  assign en            = en_q;
  assign out_valid     = (state_q == HOLD);
  assign dbg_state     = state_q;
  assign dbg_key_level = {load_level, op_level};

endmodule

// File: tb/tb_logic_operand_loader.sv
// Randomised self-checking bench for logic_operand_loader with a transaction-level
// reference model (op counter plus expected-offer queue).
module tb_logic_operand_loader;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int HOLD_CYC = DEB + SYNC + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       load_key_n = 1'b1;
  logic       op_key_n = 1'b1;
  logic [3:0] x, y, en;
  logic [7:0] z;
  logic [1:0] op, dbg_state, dbg_key_level;
  logic       out_valid;
  logic       out_ready = 1'b0;

  logic_operand_loader #(.DEB_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sw(sw), .load_key_n(load_key_n), .op_key_n(op_key_n),
    .x(x), .y(y), .z(z), .op(op), .en(en), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state), .dbg_key_level(dbg_key_level)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad = 0;
  logic [9:0] exp_q[$];   // {sw, op} of each offer still owed
  int         op_m = 0;   // model op counter
  int         hs_cnt = 0;
  int         valid_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [21:0] held;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model reaction to a clean key press: only honoured while nothing is offered.
  task automatic model_press(input bit do_load, input bit do_op);
    if (exp_q.size() == 0) begin
      if (do_op) op_m = (op_m + 1) % 4;
      if (do_load) exp_q.push_back({sw, 2'(op_m)});
    end
  endtask

  task automatic press(input bit do_load, input bit do_op, input int bounce);
    for (int i = 0; i < bounce; i++) begin
      if (do_load) load_key_n = (i % 2 == 1);
      if (do_op)   op_key_n   = (i % 2 == 1);
      tick(1);
    end
    if (do_load) load_key_n = 1'b0;
    if (do_op)   op_key_n   = 1'b0;
    tick(HOLD_CYC);
    load_key_n = 1'b1; op_key_n = 1'b1;
    tick(1);
    if (do_load) load_key_n = 1'b0;
    if (do_op)   op_key_n   = 1'b0;
    tick(1);
    load_key_n = 1'b1; op_key_n = 1'b1;
    tick(HOLD_CYC);
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("offer_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        valid_cyc++;
        if (prev_valid) check("stable_during_valid", {x, y, z, op, en}, held);
        held = {x, y, z, op, en};
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_offer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("offer_x",  x,  e[5:2]);
          check("offer_y",  y,  e[9:6]);
          check("offer_z",  z,  e[9:2]);
          check("offer_op", op, e[1:0]);
          check("offer_en", en, 4'b0001 << e[1:0]);
        end
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  int         exp_op_seq[5] = '{1, 2, 3, 0, 1};
  logic [3:0] exp_en_seq[5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

  initial begin
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(20);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_z", z, 0);
    check("rst_op", op, 0);
    check("rst_en", en, 4'b0001);
    check("rst_valid", out_valid, 0);

    // five op presses step op through 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      model_press(1'b0, 1'b1);
      press(1'b0, 1'b1, 2);
      check("opseq_op", op, exp_op_seq[i]);
      check("opseq_en", en, exp_en_seq[i]);
    end

    // bounced load with ready high: one single-cycle offer
    sw = 8'hA5; out_ready = 1'b1;
    hs_cnt = 0; valid_cyc = 0;
    model_press(1'b1, 1'b0);
    press(1'b1, 1'b0, 3);
    tick(5);
    check("bounce_offers", hs_cnt, 1);
    check("bounce_valid_cycles", valid_cyc, 1);
    check("bounce_x", x, 4'h5);
    check("bounce_y", y, 4'hA);
    check("bounce_z", z, 8'hA5);
    check("bounce_queue_empty", exp_q.size(), 0);

    // backpressure: offer held, op press and sw change ignored
    out_ready = 1'b0; sw = 8'h96;
    model_press(1'b1, 1'b0);
    press(1'b1, 1'b0, 0);
    check("hold_valid", out_valid, 1);
    sw = 8'h3C;
    model_press(1'b0, 1'b1);
    press(1'b0, 1'b1, 1);
    tick(10);
    check("hold_valid_still", out_valid, 1);
    check("hold_x", x, 4'h6);
    check("hold_y", y, 4'h9);
    check("hold_z", z, 8'h96);
    check("hold_op", op, op_m);
    out_ready = 1'b1;
    tick(2);
    check("hold_accepted", exp_q.size(), 0);
    check("hold_valid_drop", out_valid, 0);
    check("hold_op_after", op, op_m);

    // bring op to 2, then op+load together with sw=FF
    for (int i = 0; i < 4 && op_m != 2; i++) begin
      model_press(1'b0, 1'b1);
      press(1'b0, 1'b1, 0);
    end
    check("pre_simul_op", op, 2);
    sw = 8'hFF;
    model_press(1'b1, 1'b1);
    press(1'b1, 1'b1, 2);
    wait_done(50, 1'b0);
    check("simul_op", op, 3);
    check("simul_en", en, 4'b1000);
    check("simul_z", z, 8'hFF);

    // reset while holding an offer
    out_ready = 1'b0; sw = 8'h11;
    model_press(1'b1, 1'b0);
    press(1'b1, 1'b0, 0);
    check("prerst_valid", out_valid, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    op_m = 0;
    check("midrst_valid", out_valid, 0);
    check("midrst_op", op, 0);
    check("midrst_x", x, 0);
    check("midrst_y", y, 0);
    check("midrst_en", en, 4'b0001);
    sw = 8'h42; out_ready = 1'b1;
    model_press(1'b1, 1'b0);
    press(1'b1, 1'b0, 1);
    wait_done(50, 1'b0);
    check("postrst_z", z, 8'h42);

    // randomised mix of op, load and combined presses with random backpressure
    for (int it = 0; it < 30; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      sw = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      model_press(kind != 0, kind != 1);
      press(kind != 0, kind != 1, $urandom_range(0, 3));
      wait_done(200, 1'b1);
      check("rand_op", op, op_m);
    end

    out_ready = 1'b1;
    tick(5);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
